shift_mult_ctrl: RTL

SHIFT_MULT_CTRL -- requirements
Module: shift_mult_ctrl

---
 rtl/shift_mult_if.sv | 22 ++
 rtl/shift_mult_ctrl.sv | 81 ++++++++
 2 files changed

// File: rtl/shift_mult_if.sv
// Start/operand/result bundle for the shift-add multiplier.
// master drives the request, slave is the multiplier.
interface shift_mult_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_mult_ctrl.sv
// Sequential unsigned multiplier: IDLE/RUN/DONE FSM
// over a shift-left/add datapath, one bit of b per cycle.
module shift_mult_ctrl #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_mult_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic [2*N-1:0] acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    acc_step  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = {{N{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[2*N-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[N-1:1]};
        cnt_d    = cnt_q + CW'(1);
        // last step: publish the post-add value, not acc_q
        if (cnt_q == CW'(N - 1)) begin
          product_d = acc_step;
          state_d   = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
endmodule
